// File: rtl/fetch_stage.sv
// fetch_stage: PC keeper issuing word-aligned imem requests and presenting one registered instruction per slot to decode.
module fetch_stage #(
  parameter int INST_LEN = 32,
  parameter int ARCH_LEN = 32,
  parameter logic [ARCH_LEN-1:0] RESET_PC = 32'h0000_1000,
  parameter logic [INST_LEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                redirect_valid_in,
  input  logic [ARCH_LEN-1:0] redirect_pc_in,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic [INST_LEN-1:0] inst_fetched_out,
  output logic                fetch_valid_out,
  output logic [ARCH_LEN-1:0] fetch_pc_out
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [ARCH_LEN-1:0] pc, pc_n, req_pc, req_pc_n, out_pc, out_pc_n, skid_pc, skid_pc_n;
  logic [INST_LEN-1:0] out_data, out_data_n, skid_data, skid_data_n;
  logic squash, squash_n, out_valid, out_valid_n;
  logic fire, consume;
  assign imem_req_valid   = state == REQ;
  assign imem_req_addr    = pc;
  assign fire             = imem_req_valid & imem_req_ready;
  assign consume          = out_valid & ~stall_in;
  assign fetch_valid_out  = out_valid;
  assign inst_fetched_out = out_valid ? out_data : NOP_INST;
  assign fetch_pc_out     = out_valid ? out_pc : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC & ~ARCH_LEN'(3);
      req_pc    <= '0;
      squash    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= '0;
      skid_data <= '0;
      skid_pc   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_pc    <= req_pc_n;
      squash    <= squash_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_pc    <= out_pc_n;
      skid_data <= skid_data_n;
      skid_pc   <= skid_pc_n;
    end
  end
  // Skid buffer holds data exactly while in HOLD, so leaving HOLD empties it.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_pc_n    = req_pc;
    squash_n    = squash;
    out_valid_n = out_valid & ~consume;
    out_data_n  = out_data;
    out_pc_n    = out_pc;
    skid_data_n = skid_data;
    skid_pc_n   = skid_pc;
    if (redirect_valid_in) begin
      pc_n        = redirect_pc_in & ~ARCH_LEN'(3);
      out_valid_n = 1'b0;
      if (state == REQ) begin
        state_n  = fire ? WAIT : REQ;
        squash_n = fire;
      end else if (state == WAIT) begin
        state_n  = imem_rsp_valid ? REQ : WAIT;
        squash_n = ~imem_rsp_valid;
      end else
        state_n = REQ;
    end else begin
      case (state)
        BOOT: state_n = REQ;
        REQ: if (imem_req_ready) begin
          req_pc_n = pc;
          pc_n     = pc + ARCH_LEN'(4);
          state_n  = WAIT;
        end
        WAIT: if (imem_rsp_valid) begin
          if (squash) begin
            squash_n = 1'b0;
            state_n  = REQ;
          end else if (!out_valid || consume) begin
            out_valid_n = 1'b1;
            out_data_n  = imem_rsp_data;
            out_pc_n    = req_pc;
            state_n     = REQ;
          end else begin
            skid_data_n = imem_rsp_data;
            skid_pc_n   = req_pc;
            state_n     = HOLD;
          end
        end
        HOLD: if (consume) begin
          out_valid_n = 1'b1;
          out_data_n  = skid_data;
          out_pc_n    = skid_pc;
          state_n     = REQ;
        end
        default: state_n = BOOT;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed spec scenarios plus a randomized run against a queue-based fetch model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1;
  logic stall_in = 0, redirect_valid_in = 0, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] redirect_pc_in = 0, imem_rsp_data = 0;
  logic imem_req_valid, fetch_valid_out, imem_req_valid2, fetch_valid_out2;
  logic [31:0] imem_req_addr, inst_fetched_out, fetch_pc_out, imem_req_addr2, inst_fetched_out2, fetch_pc_out2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fetch_stage dut (.clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in(redirect_pc_in), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_fetched_out(inst_fetched_out), .fetch_valid_out(fetch_valid_out), .fetch_pc_out(fetch_pc_out));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst(rst), .stall_in(stall_in),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in), .imem_req_valid(imem_req_valid2),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr2), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_fetched_out(inst_fetched_out2), .fetch_valid_out(fetch_valid_out2),
    .fetch_pc_out(fetch_pc_out2));
  task automatic drive(input logic rdy, input logic rv, input logic st, input logic rd, input logic [31:0] rp);
    imem_req_ready = rdy; imem_rsp_valid = rv; stall_in = st; redirect_valid_in = rd; redirect_pc_in = rp;
    @(posedge clk); #1;
  endtask
  task automatic xfer(input logic [31:0] d);
    drive(1, 0, 0, 0, 0);
    imem_rsp_data = d;
    drive(0, 1, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1; imem_req_ready = 0; imem_rsp_valid = 0; stall_in = 0; redirect_valid_in = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic test_reset();
    rst = 1; repeat (2) @(posedge clk); #1;
    if ({imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out, inst_fetched_out} !== {1'b0, 32'h1000, 1'b0, 32'h0, NOP}) begin
      bad++; $display("FAIL reset_outputs got=%b %h %b %h %h", imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out, inst_fetched_out); end
    total++;
    rst = 0;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL boot_no_req got=%b want=0", imem_req_valid); end
    total++;
    drive(0, 0, 0, 0, 0);
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin
      bad++; $display("FAIL first_req got=%b %h want=1 00001000", imem_req_valid, imem_req_addr); end
    total++;
    xfer(32'h1234_5678);
    #2 rst = 1; #1;
    if ({imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out, inst_fetched_out} !== {1'b0, 32'h1000, 1'b0, 32'h0, NOP}) begin
      bad++; $display("FAIL async_reset got=%b %h %b %h %h", imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out, inst_fetched_out); end
    total++;
  endtask
  task automatic test_stream();
    do_reset();
    drive(0, 0, 0, 0, 0);
    imem_rsp_data = 32'h0050_0093;
    for (int k = 0; k < 3; k++) begin
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000 + 32'(4 * k)) begin
        bad++; $display("FAIL stream_req%0d got=%b %h want=1 %h", k, imem_req_valid, imem_req_addr, 32'h1000 + 32'(4 * k)); end
      total++;
      drive(1, 0, 0, 0, 0);
      if (imem_req_valid !== 1'b0 || fetch_valid_out !== 1'b0) begin
        bad++; $display("FAIL stream_gap%0d got req=%b valid=%b want 0 0", k, imem_req_valid, fetch_valid_out); end
      total++;
      drive(0, 1, 0, 0, 0);
      if ({fetch_valid_out, fetch_pc_out, inst_fetched_out} !== {1'b1, 32'h1000 + 32'(4 * k), 32'h0050_0093}) begin
        bad++; $display("FAIL stream_out%0d got=%b %h %h", k, fetch_valid_out, fetch_pc_out, inst_fetched_out); end
      total++;
    end
  endtask
  task automatic test_stall();
    do_reset();
    drive(0, 0, 0, 0, 0);
    xfer(32'hA000_1000);
    xfer(32'hA000_1004);
    drive(1, 0, 1, 0, 0);
    imem_rsp_data = 32'hA000_1008;
    drive(0, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if ({imem_req_valid, fetch_valid_out, fetch_pc_out, inst_fetched_out} !== {1'b0, 1'b1, 32'h1004, 32'hA000_1004}) begin
        bad++; $display("FAIL stall_hold%0d got req=%b %b %h %h", k, imem_req_valid, fetch_valid_out, fetch_pc_out, inst_fetched_out); end
      total++;
      if (k < 4) drive(0, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
    if ({fetch_valid_out, fetch_pc_out, inst_fetched_out, imem_req_valid, imem_req_addr} !== {1'b1, 32'h1008, 32'hA000_1008, 1'b1, 32'h100C}) begin
      bad++; $display("FAIL stall_release got=%b %h %h %b %h", fetch_valid_out, fetch_pc_out, inst_fetched_out, imem_req_valid, imem_req_addr); end
    total++;
  endtask
  task automatic test_redirect_wait();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h2002);
    if (fetch_valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rdw_squash got valid=%b req=%b want 0 0", fetch_valid_out, imem_req_valid); end
    total++;
    imem_rsp_data = 32'hDEAD_BEEF;
    drive(0, 1, 0, 0, 0);
    if ({fetch_valid_out, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h2000}) begin
      bad++; $display("FAIL rdw_target got=%b %b %h want 0 1 00002000", fetch_valid_out, imem_req_valid, imem_req_addr); end
    total++;
  endtask
  task automatic test_redirect_handshake();
    do_reset();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) xfer(32'hB000_0000 + 32'(k));
    if (imem_req_addr !== 32'h1010 || fetch_pc_out !== 32'h100C) begin
      bad++; $display("FAIL rdh_setup got addr=%h pc=%h want 00001010 0000100c", imem_req_addr, fetch_pc_out); end
    total++;
    drive(1, 0, 0, 1, 32'h3000);
    if (fetch_valid_out !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rdh_flush got valid=%b req=%b want 0 0", fetch_valid_out, imem_req_valid); end
    total++;
    drive(0, 1, 0, 0, 0);
    if ({fetch_valid_out, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h3000}) begin
      bad++; $display("FAIL rdh_drop got=%b %b %h want 0 1 00003000", fetch_valid_out, imem_req_valid, imem_req_addr); end
    total++;
    xfer(32'hC0DE_0001);
    if ({fetch_valid_out, fetch_pc_out, inst_fetched_out} !== {1'b1, 32'h3000, 32'hC0DE_0001}) begin
      bad++; $display("FAIL rdh_target got=%b %h %h", fetch_valid_out, fetch_pc_out, inst_fetched_out); end
    total++;
  endtask
  task automatic test_hold_redirect();
    do_reset();
    drive(0, 0, 0, 0, 0);
    xfer(32'hD000_1000);
    drive(1, 0, 1, 0, 0);
    imem_rsp_data = 32'hD000_1004;
    drive(0, 1, 1, 0, 0);
    if ({imem_req_valid, fetch_valid_out, fetch_pc_out} !== {1'b0, 1'b1, 32'h1000}) begin
      bad++; $display("FAIL hold_enter got=%b %b %h want 0 1 00001000", imem_req_valid, fetch_valid_out, fetch_pc_out); end
    total++;
    drive(0, 0, 1, 1, 32'h4000);
    if ({fetch_valid_out, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h4000}) begin
      bad++; $display("FAIL hold_redirect got=%b %b %h want 0 1 00004000", fetch_valid_out, imem_req_valid, imem_req_addr); end
    total++;
    drive(0, 0, 0, 0, 0);
    if (fetch_valid_out !== 1'b0) begin bad++; $display("FAIL hold_skid_flushed got=%b want=0", fetch_valid_out); end
    total++;
  endtask
  task automatic test_wrap();
    do_reset();
    drive(0, 0, 0, 0, 0);
    if (imem_req_valid2 !== 1'b1 || imem_req_addr2 !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_first got=%b %h want 1 fffffffc", imem_req_valid2, imem_req_addr2); end
    total++;
    xfer(32'hE000_0001);
    if ({imem_req_valid2, imem_req_addr2, fetch_valid_out2, fetch_pc_out2} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC}) begin
      bad++; $display("FAIL wrap_next got=%b %h %b %h", imem_req_valid2, imem_req_addr2, fetch_valid_out2, fetch_pc_out2); end
    total++;
    imem_rsp_data = 32'hBAD0_BAD0;
    drive(0, 1, 1, 0, 0);
    if ({imem_req_valid2, imem_req_addr2, fetch_valid_out2, fetch_pc_out2, inst_fetched_out2} !== {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hE000_0001}) begin
      bad++; $display("FAIL wrap_spurious got=%b %h %b %h %h", imem_req_valid2, imem_req_addr2, fetch_valid_out2, fetch_pc_out2, inst_fetched_out2); end
    total++;
  endtask
  task automatic test_random();
    bit m_boot = 1, m_out = 0, m_sq = 0, m_ov = 0, pend = 0, exp_req, fire, cons, free;
    logic [31:0] m_pc = 32'h1000, m_rpc = 0, m_od = 0, m_op = 0;
    logic [63:0] m_skid[$];
    int dly = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      exp_req = !m_boot && !m_out && m_skid.size() == 0;
      if ({imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out, inst_fetched_out} !==
          {exp_req, m_pc, m_ov, m_ov ? m_op : 32'h0, m_ov ? m_od : NOP}) begin
        bad++; $display("FAIL random_cycle%0d got=%b %h %b %h %h want=%b %h %b %h %h", n, imem_req_valid, imem_req_addr,
          fetch_valid_out, fetch_pc_out, inst_fetched_out, exp_req, m_pc, m_ov, m_ov ? m_op : 32'h0, m_ov ? m_od : NOP); end
      total++;
      imem_req_ready = 1'($urandom_range(0, 1));
      stall_in = $urandom_range(0, 3) == 0;
      redirect_valid_in = $urandom_range(0, 15) == 0;
      redirect_pc_in = $urandom;
      imem_rsp_data = $urandom;
      imem_rsp_valid = 0;
      if (pend) begin
        if (dly == 0) begin imem_rsp_valid = 1; pend = 0; end
        else dly--;
      end else if (!m_out && $urandom_range(0, 15) == 0) imem_rsp_valid = 1;
      @(posedge clk);
      fire = exp_req && imem_req_ready;
      cons = m_ov && !stall_in;
      free = !m_ov || cons;
      if (redirect_valid_in) begin
        m_pc = {redirect_pc_in[31:2], 2'b00};
        m_ov = 0; m_boot = 0; m_skid.delete();
        if (fire) begin m_out = 1; m_sq = 1; end
        else if (m_out) begin
          if (imem_rsp_valid) begin m_out = 0; m_sq = 0; end
          else m_sq = 1;
        end
      end else begin
        if (cons) m_ov = 0;
        if (m_boot) m_boot = 0;
        else if (fire) begin m_rpc = m_pc; m_pc = m_pc + 4; m_out = 1; end
        else if (m_out && imem_rsp_valid) begin
          m_out = 0;
          if (m_sq) m_sq = 0;
          else if (free) begin m_ov = 1; m_od = imem_rsp_data; m_op = m_rpc; end
          else m_skid.push_back({imem_rsp_data, m_rpc});
        end else if (m_skid.size() > 0 && cons) begin
          {m_od, m_op} = m_skid.pop_front();
          m_ov = 1;
        end
      end
      if (fire) begin pend = 1; dly = $urandom_range(0, 2); end
      #1;
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_hold_redirect();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
